// File: rtl/axi_llc_pkg.sv
// Shared types for the LLC lookup controller.
//   lookup_state_e : lookup sequencer states
//   lookup_desc_t  : descriptor handed to the miss/refill path
// The descriptor is sized by the Llc* defaults below. Widen these together
// with any non-default parameterisation of axi_llc_lookup_ctrl.
package axi_llc_pkg;

  localparam int unsigned LlcWays       = 4;
  localparam int unsigned LlcIndexWidth = 8;
  localparam int unsigned LlcTagWidth   = 20;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TAG_RD   = 3'd1,
    TAG_WAIT = 3'd2,
    EVICT    = 3'd3,
    TAG_WR   = 3'd4,
    DESC     = 3'd5
  } lookup_state_e;

  typedef struct packed {
    logic [LlcIndexWidth-1:0] index;
    logic [LlcWays-1:0]       way;
    logic                     hit;
    logic                     evict;
    logic [LlcTagWidth-1:0]   evict_tag;
    logic                     error;
  } lookup_desc_t;

endpackage

// File: rtl/axi_llc_way_sel.sv
// Combinational way selection for the LLC lookup.
//   valid_i/spm_lock_i/cmp_tags_i/req_tag_i -> hit_vec_o : per-way hit compare
//   mux_tags_i/mux_way_i -> mux_tag_o                    : one-hot tag mux
module axi_llc_way_sel #(
  parameter int unsigned Ways     = 4,
  parameter int unsigned TagWidth = 20
) (
  input  logic [Ways-1:0]          valid_i,
  input  logic [Ways-1:0]          spm_lock_i,
  input  logic [Ways*TagWidth-1:0] cmp_tags_i,
  input  logic [TagWidth-1:0]      req_tag_i,
  output logic [Ways-1:0]          hit_vec_o,
  input  logic [Ways*TagWidth-1:0] mux_tags_i,
  input  logic [Ways-1:0]          mux_way_i,
  output logic [TagWidth-1:0]      mux_tag_o
);

  always_comb begin
    hit_vec_o = '0;
    mux_tag_o = '0;
    for (int unsigned w = 0; w < Ways; w++) begin
      hit_vec_o[w] = valid_i[w] & ~spm_lock_i[w] &
                     (cmp_tags_i[w*TagWidth +: TagWidth] == req_tag_i);
      // AND-OR mux: correct only for a one-hot (or zero) select
      mux_tag_o = mux_tag_o |
                  ({TagWidth{mux_way_i[w]}} & mux_tags_i[w*TagWidth +: TagWidth]);
    end
  end

endmodule

// File: rtl/axi_llc_lookup_ctrl.sv
// LLC lookup sequencer: one lookup at a time through tag read, hit check,
// victim selection, tag write and descriptor hand-off.
//   req_*      : incoming lookup (index, tag, write flag)
//   tag_rd_*   : tag SRAM set read, data returns one cycle after grant
//   evict_*    : pseudo-random eviction unit request/response
//   tag_wr_*   : tag SRAM write of the newly allocated line
//   desc_*     : lookup result to the downstream miss/refill path
module axi_llc_lookup_ctrl
  import axi_llc_pkg::*;
#(
  parameter int unsigned SetAssociativity = LlcWays,
  parameter int unsigned IndexWidth       = LlcIndexWidth,
  parameter int unsigned TagWidth         = LlcTagWidth
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [IndexWidth-1:0]            req_index_i,
  input  logic [TagWidth-1:0]              req_tag_i,
  input  logic                             req_write_i,
  input  logic [SetAssociativity-1:0]      spm_lock_i,
  output logic                             tag_rd_req_o,
  input  logic                             tag_rd_gnt_i,
  output logic [IndexWidth-1:0]            tag_rd_index_o,
  input  logic                             tag_rvalid_i,
  input  logic [SetAssociativity-1:0]      tag_valid_i,
  input  logic [SetAssociativity-1:0]      tag_dirty_i,
  input  logic [SetAssociativity*TagWidth-1:0] tag_tag_i,
  output logic                             evict_req_o,
  output logic [SetAssociativity-1:0]      evict_tag_valid_o,
  output logic [SetAssociativity-1:0]      evict_tag_dirty_o,
  input  logic [SetAssociativity-1:0]      evict_way_ind_i,
  input  logic                             evict_evict_i,
  input  logic                             evict_valid_i,
  output logic                             tag_wr_req_o,
  input  logic                             tag_wr_gnt_i,
  output logic [IndexWidth-1:0]            tag_wr_index_o,
  output logic [SetAssociativity-1:0]      tag_wr_way_o,
  output logic [TagWidth-1:0]              tag_wr_tag_o,
  output logic                             tag_wr_dirty_o,
  output logic                             desc_valid_o,
  input  logic                             desc_ready_i,
  output logic [IndexWidth-1:0]            desc_index_o,
  output logic [SetAssociativity-1:0]      desc_way_o,
  output logic                             desc_hit_o,
  output logic                             desc_evict_o,
  output logic [TagWidth-1:0]              desc_evict_tag_o,
  output logic                             desc_error_o
);

  lookup_state_e                       state_q, state_d;
  lookup_desc_t                        desc_q, desc_d;
  logic [TagWidth-1:0]                 tag_q, tag_d;
  logic                                write_q, write_d;
  logic [SetAssociativity-1:0]         valid_q, valid_d;
  logic [SetAssociativity-1:0]         dirty_q, dirty_d;
  logic [SetAssociativity*TagWidth-1:0] tags_q, tags_d;
  logic [SetAssociativity-1:0]         hit_vec;
  logic [TagWidth-1:0]                 victim_tag;

  // Hit compare runs on the live read data; the victim mux uses the latched set.
  axi_llc_way_sel #(
    .Ways     (SetAssociativity),
    .TagWidth (TagWidth)
  ) i_way_sel (
    .valid_i    (tag_valid_i),
    .spm_lock_i (spm_lock_i),
    .cmp_tags_i (tag_tag_i),
    .req_tag_i  (tag_q),
    .hit_vec_o  (hit_vec),
    .mux_tags_i (tags_q),
    .mux_way_i  (evict_way_ind_i),
    .mux_tag_o  (victim_tag)
  );

  always_comb begin
    state_d = state_q;
    desc_d  = desc_q;
    tag_d   = tag_q;
    write_d = write_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    tags_d  = tags_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          // Clearing the descriptor here lets hit/error paths leave way/evict at 0.
          desc_d       = '0;
          desc_d.index = req_index_i;
          tag_d        = req_tag_i;
          write_d      = req_write_i;
          state_d      = TAG_RD;
        end
      end
      TAG_RD: begin
        if (tag_rd_gnt_i) state_d = TAG_WAIT;
      end
      TAG_WAIT: begin
        if (tag_rvalid_i) begin
          valid_d = tag_valid_i;
          dirty_d = tag_dirty_i;
          tags_d  = tag_tag_i;
          if (|hit_vec) begin
            desc_d.hit = 1'b1;
            desc_d.way = hit_vec;
            state_d    = DESC;
          end else if (&spm_lock_i) begin
            desc_d.error = 1'b1;
            state_d      = DESC;
          end else begin
            state_d = EVICT;
          end
        end
      end
      EVICT: begin
        if (evict_valid_i) begin
          desc_d.way       = evict_way_ind_i;
          desc_d.evict     = evict_evict_i;
          desc_d.evict_tag = evict_evict_i ? victim_tag : '0;
          state_d          = TAG_WR;
        end
      end
      TAG_WR: begin
        if (tag_wr_gnt_i) state_d = DESC;
      end
      DESC: begin
        if (desc_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      desc_q  <= '0;
      tag_q   <= '0;
      write_q <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
      tags_q  <= '0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      tag_q   <= tag_d;
      write_q <= write_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tags_q  <= tags_d;
    end
  end

  assign req_ready_o       = (state_q == IDLE);
  assign tag_rd_req_o      = (state_q == TAG_RD);
  assign tag_rd_index_o    = desc_q.index;
  assign evict_req_o       = (state_q == EVICT);
  assign evict_tag_valid_o = valid_q;
  assign evict_tag_dirty_o = dirty_q;
  assign tag_wr_req_o      = (state_q == TAG_WR);
  assign tag_wr_index_o    = desc_q.index;
  assign tag_wr_way_o      = desc_q.way;
  assign tag_wr_tag_o      = tag_q;
  assign tag_wr_dirty_o    = write_q;
  assign desc_valid_o      = (state_q == DESC);
  assign desc_index_o      = desc_q.index;
  assign desc_way_o        = desc_q.way;
  assign desc_hit_o        = desc_q.hit;
  assign desc_evict_o      = desc_q.evict;
  assign desc_evict_tag_o  = desc_q.evict_tag;
  assign desc_error_o      = desc_q.error;

  a_single_hit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == TAG_WAIT && tag_rvalid_i) |-> $onehot0(hit_vec));

  a_victim_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == EVICT && evict_valid_i) |->
      ($onehot(evict_way_ind_i) && ((evict_way_ind_i & spm_lock_i) == '0)));

endmodule

// File: doc/axi_llc_lookup_ctrl.md
Name: axi_llc_lookup_ctrl

Overview:
- Sequences one cache lookup at a time through the tag store and the pseudo-random eviction unit.
- Accepts a request (index, tag, write flag) and reads all ways of the set. It detects a hit, or asks the eviction unit for a victim way.
- On a miss it writes the new tag, then emits one descriptor (way, hit, evict, old tag, error) to the downstream miss/refill path.
- Sits between the AXI request splitter and the tag SRAM/eviction unit.

Parameters:
- SetAssociativity, 4, number of ways; width of way_ind_t; must be >= 1.
- IndexWidth, 8, set index width.
- TagWidth, 20, tag width.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous reset, active low
- req_valid_i / req_ready_o  in/out  1  request handshake
- req_index_i  in  IndexWidth  set index
- req_tag_i  in  TagWidth  request tag
- req_write_i  in  1  request is a write; becomes the new line's dirty bit
- spm_lock_i  in  SetAssociativity  ways configured as SPM; static during a lookup
- tag_rd_req_o / tag_rd_gnt_i  out/in  1  tag read request and grant
- tag_rd_index_o  out  IndexWidth  index of the set to read
- tag_rvalid_i  in  1  read data valid, exactly 1 cycle after a granted read
- tag_valid_i, tag_dirty_i  in  SetAssociativity  per-way valid and dirty bits
- tag_tag_i  in  SetAssociativity*TagWidth  per-way stored tags; way w at [w*TagWidth +: TagWidth]
- evict_req_o  out  1  request to the eviction unit
- evict_tag_valid_o, evict_tag_dirty_o  out  SetAssociativity  latched valid/dirty bits fed to the eviction unit
- evict_way_ind_i  in  SetAssociativity  one-hot victim way
- evict_evict_i  in  1  victim line is dirty and must be written back
- evict_valid_i  in  1  victim choice is valid
- tag_wr_req_o / tag_wr_gnt_i  out/in  1  tag write request and grant
- tag_wr_index_o  out  IndexWidth  index to write
- tag_wr_way_o  out  SetAssociativity  one-hot way to write
- tag_wr_tag_o  out  TagWidth  new tag
- tag_wr_dirty_o  out  1  new dirty bit
- desc_valid_o / desc_ready_i  out/in  1  descriptor handshake
- desc_index_o  out  IndexWidth  set index
- desc_way_o  out  SetAssociativity  one-hot way
- desc_hit_o  out  1  lookup hit
- desc_evict_o  out  1  dirty victim must be written back
- desc_evict_tag_o  out  TagWidth  tag of the victim line
- desc_error_o  out  1  no allocatable way

Behaviour:
- FSM states: IDLE, TAG_RD, TAG_WAIT, EVICT, TAG_WR, DESC. Reset state is IDLE.
- Reset values: all outputs 0, except req_ready_o=1. All latched request and tag fields reset to 0.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch index, tag and write flag, then go to TAG_RD.
  - req_ready_o is 0 in every other state.
- TAG_RD:
  - tag_rd_req_o=1 with tag_rd_index_o held stable until tag_rd_gnt_i.
  - On grant go to TAG_WAIT.
- TAG_WAIT:
  - On tag_rvalid_i, latch valid, dirty and tags.
  - hit_vec[w] = valid[w] & (tag[w]==req_tag) & ~spm_lock_i[w].
  - If hit_vec != 0: desc_hit=1, desc_way=hit_vec, go to DESC. No tag write.
  - Else if spm_lock_i == '1: desc_error=1, desc_way=0, go to DESC.
  - Else go to EVICT.
- EVICT:
  - evict_req_o=1, evict_tag_* driven from the latched registers and held stable.
  - On evict_valid_i, latch way, evict flag, and the victim tag (selected by one-hot mux).
  - desc_evict = evict_evict_i. Go to TAG_WR.
- TAG_WR:
  - tag_wr_req_o=1 with tag_wr_index_o=latched index, tag_wr_way_o=victim way, tag_wr_tag_o=req tag, tag_wr_dirty_o=req_write.
  - Fields held stable until tag_wr_gnt_i; on grant go to DESC.
- DESC:
  - desc_valid_o=1, all desc fields stable until desc_ready_i.
  - On desc_ready_i go to IDLE.
  - desc_evict_tag_o is 0 unless desc_evict_o=1.
- Back-to-back: a new request is accepted in the cycle after the descriptor handshake (IDLE cycle); no overlap.
- Miss latency with zero-wait grants and ready:
  - Accept at cycle 0.
  - Read granted at cycle 1, rvalid at 2.
  - evict_valid at 3, write granted at 4.
  - desc_valid at 5.
- Hit latency: desc_valid at cycle 3.
- Multiple matching valid ways: flagged as an assertion failure.
- An asserted evict_way_ind_i that is not one-hot, or that overlaps spm_lock_i: assertion failure.
- Reset asserted mid-operation: immediate return to IDLE. Any outstanding tag_rvalid_i after reset is ignored in IDLE.
- tag_rvalid_i outside TAG_WAIT is ignored.

Decomposition:
- Add lookup_state_e and a lookup_desc_t struct (index, way, hit, evict, evict_tag, error) to axi_llc_pkg.
- One sub-module: axi_llc_way_sel. It is combinational: one-hot mux of tag_tag_i by way, plus the hit-vector compare.

Test Plan:
- Hit: set 0x12 with way2 valid, tag 0xABCDE; request tag 0xABCDE -> desc at cycle 3: hit=1, way=4'b0100, evict=0, no tag_wr_req_o.
- Fill empty set: all invalid, req_write=1 -> one EVICT cycle, tag write of tag 0x11111 with dirty=1 to a way with valid=0 -> desc: hit=0, evict=0.
- Dirty victim: all ways valid+dirty, tags 0x1..0x4, no match -> desc: evict=1, evict_tag equals the stored tag of the chosen way, way one-hot.
- All SPM: spm_lock_i=4'b1111 -> desc: error=1, way=0, evict_req_o never asserted.
- Backpressure: tag_rd_gnt_i delayed 3 cycles and desc_ready_i delayed 4 cycles -> outputs stable during stalls, req_ready_o=0 until the cycle after the desc handshake.
- Reset in EVICT: rst_ni low for 1 cycle -> all outputs reset, req_ready_o=1; the next request completes normally.
